// File: rtl/cvxif_issuer.sv
// cvxif_issuer: CPU-side CV-X-IF issuer; one outstanding instruction through IDLE/ISSUE/COMMIT/RESULT.
package cvxif_issuer_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned X_ID_WIDTH = 2;
  typedef struct packed {
    logic                  x_compressed_valid;
    logic [15:0]           x_compressed_instr;
    logic [X_ID_WIDTH-1:0] x_compressed_id;
    logic                  x_issue_valid;
    logic [31:0]           x_issue_instr;
    logic [X_ID_WIDTH-1:0] x_issue_id;
    logic [2:0][XLEN-1:0]  x_issue_rs;
    logic [2:0]            x_issue_rs_valid;
    logic                  x_commit_valid;
    logic [X_ID_WIDTH-1:0] x_commit_id;
    logic                  x_commit_kill;
    logic                  x_mem_ready;
    logic                  x_mem_result_valid;
    logic [XLEN-1:0]       x_mem_result_rdata;
    logic                  x_result_ready;
  } cvxif_req_t;
  typedef struct packed {
    logic                  x_issue_ready;
    logic                  x_issue_accept;
    logic                  x_issue_writeback;
    logic                  x_result_valid;
    logic [X_ID_WIDTH-1:0] x_result_id;
    logic [XLEN-1:0]       x_result_data;
    logic [4:0]            x_result_rd;
    logic                  x_result_we;
    logic                  x_result_exc;
  } cvxif_resp_t;
endpackage

module cvxif_issuer
  import cvxif_issuer_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024
)(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] rs3_i,
  input  logic            kill_i,
  output logic            wb_valid_o,
  output logic            wb_we_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            illegal_o,
  output logic            timeout_o,
  output cvxif_req_t      cvxif_req_o,
  input  cvxif_resp_t     cvxif_resp_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT, RESULT} state_t;
  state_t                state_q, state_d;
  logic [31:0]           instr_q;
  logic [2:0][XLEN-1:0]  rs_q;
  logic [X_ID_WIDTH-1:0] id_q;
  logic                  wbk_q;
  logic                  match, done, illegal_d, timeout_hit;
  assign match = cvxif_resp_i.x_result_valid && cvxif_resp_i.x_result_id == id_q;
  always_comb begin
    state_d                   = state_q;
    done                      = 1'b0;
    illegal_d                 = 1'b0;
    cvxif_req_o               = '0;
    cvxif_req_o.x_issue_instr = instr_q;
    cvxif_req_o.x_issue_rs    = rs_q;
    cvxif_req_o.x_issue_id    = id_q;
    cvxif_req_o.x_commit_id   = id_q;
    instr_ready_o             = state_q == IDLE;
    case (state_q)
      IDLE: state_d = instr_valid_i ? ISSUE : IDLE;
      ISSUE: begin
        cvxif_req_o.x_issue_valid    = 1'b1;
        cvxif_req_o.x_issue_rs_valid = 3'b111;
        if (cvxif_resp_i.x_issue_ready) begin
          state_d   = cvxif_resp_i.x_issue_accept ? COMMIT : IDLE;
          illegal_d = ~cvxif_resp_i.x_issue_accept;
        end
      end
      COMMIT: begin
        cvxif_req_o.x_commit_valid = 1'b1;
        cvxif_req_o.x_commit_kill  = kill_i;
        state_d = kill_i ? IDLE : RESULT;
      end
      default: begin
        cvxif_req_o.x_result_ready = 1'b1;
        done    = match;
        state_d = (match || timeout_hit) ? IDLE : RESULT;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      rs_q       <= '0;
      id_q       <= '0;
      wbk_q      <= 1'b0;
      wb_valid_o <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
      illegal_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && instr_valid_i) begin
        instr_q <= instr_i;
        rs_q    <= {rs3_i, rs2_i, rs1_i};
      end
      if (state_q == ISSUE && cvxif_resp_i.x_issue_ready)
        wbk_q <= cvxif_resp_i.x_issue_writeback;
      if (state_q != IDLE && state_d == IDLE)
        id_q <= id_q + 1'b1;
      wb_valid_o <= done;
      wb_we_o    <= done & cvxif_resp_i.x_result_we & wbk_q & ~cvxif_resp_i.x_result_exc;
      illegal_o  <= illegal_d;
      if (done) begin
        wb_rd_o   <= cvxif_resp_i.x_result_rd;
        wb_data_o <= cvxif_resp_i.x_result_data;
      end
    end
  end
`ifdef CVXIF_ISSUER_TIMEOUT_EN
  localparam int unsigned CW = TimeoutCycles > 1 ? $clog2(TimeoutCycles) : 1;
  logic [CW-1:0] cnt_q;
  assign timeout_hit = cnt_q == CW'(TimeoutCycles - 1);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_o <= 1'b0;
    end else begin
      cnt_q     <= (state_q == RESULT && state_d == RESULT) ? cnt_q + 1'b1 : '0;
      timeout_o <= state_q == RESULT && !match && timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif
endmodule

// File: tb/tb_cvxif_issuer.sv
// tb_cvxif_issuer: table-driven, directed and randomized checks of cvxif_issuer acting as the coprocessor.
module tb_cvxif_issuer;
  import cvxif_issuer_pkg::*;
  localparam int NID = 1 << X_ID_WIDTH;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            instr_valid = 1'b0;
  logic            instr_ready;
  logic [31:0]     instr = '0;
  logic [XLEN-1:0] rs1 = '0, rs2 = '0, rs3 = '0;
  logic            kill = 1'b0;
  logic            wb_valid, wb_we, illegal, timeout;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  cvxif_req_t      req;
  cvxif_resp_t     resp = '0;
  always #5 clk = ~clk;
  cvxif_issuer #(.TimeoutCycles(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .instr_i(instr), .rs1_i(rs1), .rs2_i(rs2), .rs3_i(rs3), .kill_i(kill),
    .wb_valid_o(wb_valid), .wb_we_o(wb_we), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .illegal_o(illegal), .timeout_o(timeout), .cvxif_req_o(req), .cvxif_resp_i(resp)
  );
  typedef struct {
    logic [31:0] instr, rs1, rs2, rs3;
    bit          accept, wbk, kill;
    int          rdelay;
    bit          stale;
    logic [31:0] data;
    logic [4:0]  rd;
    bit          we, exc;
    bit          e_illegal, e_wb, e_we;
    logic [31:0] e_data;
  } vec_t;
  int nvec = 0, nfail = 0;
  int exp_id = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(logic [31:0] i, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                              bit acc, bit wbk, bit kl, int dly, bit stl, logic [31:0] d,
                              logic [4:0] rd, bit we, bit exc, bit eil, bit ewb, bit ewe);
    vec_t v;
    v.instr = i; v.rs1 = a; v.rs2 = b; v.rs3 = c;
    v.accept = acc; v.wbk = wbk; v.kill = kl; v.rdelay = dly; v.stale = stl;
    v.data = d; v.rd = rd; v.we = we; v.exc = exc;
    v.e_illegal = eil; v.e_wb = ewb; v.e_we = ewe; v.e_data = d;
    return v;
  endfunction
  task automatic run(input vec_t v);
    chk("idle_ready", instr_ready, 1);
    instr_valid = 1'b1; instr = v.instr; rs1 = v.rs1; rs2 = v.rs2; rs3 = v.rs3;
    step();
    instr_valid = 1'b0; instr = ~v.instr; rs1 = $urandom; rs2 = $urandom; rs3 = $urandom;
    for (int c = 0; c <= v.rdelay; c++) begin
      chk("issue_valid", req.x_issue_valid, 1);
      chk("issue_instr", req.x_issue_instr, v.instr);
      chk("issue_rs1", req.x_issue_rs[0], v.rs1);
      chk("issue_rs2", req.x_issue_rs[1], v.rs2);
      chk("issue_rs3", req.x_issue_rs[2], v.rs3);
      chk("issue_rs_valid", req.x_issue_rs_valid, 3'b111);
      chk("issue_id", req.x_issue_id, exp_id);
      chk("busy_ready", instr_ready, 0);
      chk("tieoffs", {req.x_compressed_valid, req.x_mem_ready, req.x_mem_result_valid}, 0);
      if (c == v.rdelay) begin
        resp.x_issue_ready = 1'b1; resp.x_issue_accept = v.accept; resp.x_issue_writeback = v.wbk;
      end
      step();
    end
    resp.x_issue_ready = 1'b0; resp.x_issue_accept = 1'($urandom); resp.x_issue_writeback = 1'($urandom);
    chk("illegal_pulse", illegal, v.e_illegal);
    if (!v.accept) begin
      chk("illegal_no_commit", req.x_commit_valid, 0);
      chk("illegal_idle", instr_ready, 1);
      step();
      chk("illegal_end", illegal, 0);
      exp_id = (exp_id + 1) % NID;
      return;
    end
    chk("commit_valid", req.x_commit_valid, 1);
    chk("commit_id", req.x_commit_id, exp_id);
    kill = v.kill;
    #1;
    chk("commit_kill", req.x_commit_kill, v.kill);
    step();
    kill = 1'b0;
    chk("commit_once", req.x_commit_valid, 0);
    if (v.kill) begin
      chk("kill_idle", instr_ready, 1);
      step();
      chk("kill_no_wb", wb_valid, 0);
      exp_id = (exp_id + 1) % NID;
      return;
    end
    chk("result_ready", req.x_result_ready, 1);
    if (v.stale) begin
      resp.x_result_valid = 1'b1; resp.x_result_id = X_ID_WIDTH'((exp_id + 3) % NID);
      resp.x_result_data = ~v.data; resp.x_result_rd = v.rd ^ 5'd1; resp.x_result_we = 1'b1;
      resp.x_result_exc = 1'b0;
      step();
      chk("stale_no_wb", wb_valid, 0);
      chk("stale_still_waiting", req.x_result_ready, 1);
    end
    resp.x_result_valid = 1'b1; resp.x_result_id = X_ID_WIDTH'(exp_id);
    resp.x_result_data = v.data; resp.x_result_rd = v.rd; resp.x_result_we = v.we; resp.x_result_exc = v.exc;
    step();
    resp.x_result_valid = 1'b0;
    chk("wb_valid", wb_valid, v.e_wb);
    chk("wb_data", wb_data, v.e_data);
    chk("wb_rd", wb_rd, v.rd);
    chk("wb_we", wb_we, v.e_we);
    chk("done_idle", instr_ready, 1);
    exp_id = (exp_id + 1) % NID;
    step();
    chk("wb_pulse_end", wb_valid, 0);
  endtask
  vec_t tbl[8];
  initial begin
    tbl[0] = mk(32'h002082b3, 1, 2, 3, 1, 1, 0, 0, 0, 6, 5, 1, 0, 0, 1, 1);
    tbl[1] = mk(32'h0000000b, 4, 5, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[2] = mk(32'h0000002b, 7, 8, 9, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3] = mk(32'hcafe005b, 32'h11, 32'h22, 32'h33, 1, 1, 0, 5, 0, 32'hdeadbeef, 31, 1, 0, 0, 1, 1);
    tbl[4] = mk(32'h1234567b, 9, 9, 9, 1, 1, 0, 1, 0, 32'h55, 3, 1, 1, 0, 1, 0);
    tbl[5] = mk(32'h0badf00b, 1, 1, 1, 1, 0, 0, 0, 0, 32'h77, 7, 1, 0, 0, 1, 0);
    tbl[6] = mk(32'h0000102b, 2, 2, 2, 1, 1, 0, 2, 0, 32'h99, 9, 0, 0, 0, 1, 0);
    tbl[7] = mk(32'hffffffff, 3, 3, 3, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0);
    #2;
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_valids", {req.x_issue_valid, req.x_commit_valid, req.x_result_ready,
                       req.x_compressed_valid, req.x_mem_ready, req.x_mem_result_valid}, 0);
    chk("rst_pulses", {wb_valid, wb_we, illegal, timeout}, 0);
    chk("rst_id", req.x_issue_id, 0);
    chk("rst_operands", {req.x_issue_instr, req.x_issue_rs[0]}, 0);
    step();
    rst_n = 1'b1;
    step();
    foreach (tbl[i]) run(tbl[i]);
    instr_valid = 1'b1; instr = 32'h00a00093; rs1 = 5;
    step();
    instr_valid = 1'b0;
    resp.x_issue_ready = 1'b1; resp.x_issue_accept = 1'b1; resp.x_issue_writeback = 1'b1;
    step();
    resp.x_issue_ready = 1'b0;
    chk("pre_rst_commit", req.x_commit_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_commit", req.x_commit_valid, 0);
    chk("async_rst_ready", instr_ready, 1);
    chk("async_rst_id", req.x_commit_id, 0);
    step();
    rst_n = 1'b1;
    exp_id = 0;
    step();
    chk("post_rst_no_wb", wb_valid, 0);
    run(mk(32'h0000000b, 10, 20, 30, 1, 1, 0, 0, 1, 32'h3c, 12, 1, 0, 0, 1, 1));
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.instr = $urandom; v.rs1 = $urandom; v.rs2 = $urandom; v.rs3 = $urandom;
      v.accept = $urandom_range(0, 3) != 0;
      v.wbk = 1'($urandom); v.kill = $urandom_range(0, 3) == 0;
      v.rdelay = $urandom_range(0, 3); v.stale = 1'($urandom);
      v.data = v.rs1 + v.rs2; v.rd = 5'($urandom);
      v.we = 1'($urandom); v.exc = $urandom_range(0, 3) == 0;
      v.e_illegal = !v.accept;
      v.e_wb = v.accept && !v.kill;
      v.e_we = v.e_wb && v.we && v.wbk && !v.exc;
      v.e_data = v.e_wb ? v.data : wb_data;
      run(v);
    end
`ifdef CVXIF_ISSUER_TIMEOUT_EN
    instr_valid = 1'b1; instr = 32'h0000007b;
    step();
    instr_valid = 1'b0;
    resp.x_issue_ready = 1'b1; resp.x_issue_accept = 1'b1; resp.x_issue_writeback = 1'b1;
    step();
    resp.x_issue_ready = 1'b0;
    step();
    for (int k = 1; k < 16; k++) begin
      chk("tmo_waiting", {req.x_result_ready, timeout}, 2'b10);
      step();
    end
    chk("tmo_last_wait", {req.x_result_ready, timeout}, 2'b10);
    step();
    chk("tmo_pulse", timeout, 1);
    chk("tmo_idle", instr_ready, 1);
    chk("tmo_no_wb", wb_valid, 0);
    exp_id = (exp_id + 1) % NID;
    step();
    chk("tmo_pulse_end", timeout, 0);
    for (int n = 0; n <= NID; n++)
      run(mk(32'h100 + n, n, n, n, 1, 1, 0, 0, 0, n, 5'(n), 1, 0, 0, 1, 1));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
